// File: rtl/fifo_ctrl_single_clock_pkg.sv
// Shared widths and types for the single-clock FIFO controller.
package fifo_ctrl_single_clock_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int ADDR_WIDTH  = 4;
    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam int AFULL_LEVEL = 12;

    typedef logic                  bit_t;
    typedef logic [DATA_WIDTH-1:0] DATA_W;
    typedef logic [ADDR_WIDTH-1:0] ADDR_W;
    typedef logic [ADDR_WIDTH:0]   PTR_W;
    typedef logic [ADDR_WIDTH:0]   CNT_W;

endpackage

// File: rtl/fifo_ctrl_single_clock_if.sv
// Producer/consumer side of the FIFO: push/pop handshake, read data and status.
interface fifo_ctrl_single_clock_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, push_data, pop,
        input  rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  push, push_data, pop,
        output rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl_single_clock_ptr.sv
// Wrapping FIFO pointer: the MSB is the lap bit, the low bits address the RAM.
module fifo_ptr #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [ADDR_WIDTH:0]   ptr,
    output logic [ADDR_WIDTH-1:0] addr
);
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ONE;
        end
    end

    assign addr = ptr[ADDR_WIDTH-1:0];
endmodule

// File: rtl/fifo_ctrl_single_clock.sv
// Single-clock FIFO controller driving an external simple dual-port RAM.
// Flags decode from the registered count; read data returns one cycle after pop.
module fifo_ctrl_single_clock
    import fifo_ctrl_single_clock_pkg::*;
#(
    parameter int DATA_WIDTH  = fifo_ctrl_single_clock_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = fifo_ctrl_single_clock_pkg::ADDR_WIDTH,
    parameter int AFULL_LEVEL = fifo_ctrl_single_clock_pkg::AFULL_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_ctrl_single_clock_if.slave bus,
    output logic                  ram_en_w,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_en_r,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_out
);
    localparam int                  FIFO_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL   = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AFULL  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE        = 1;

    logic                  push_ok;
    logic                  pop_ok;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  rd_valid_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full_w;
    logic                  empty_w;

    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);

    // Acceptance looks only at this cycle's flags: a same-cycle pop does not make room.
    assign push_ok = bus.push & ~full_w;
    assign pop_ok  = bus.pop  & ~empty_w;

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push_ok),
        .ptr   (wr_ptr),
        .addr  (wr_addr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_ok),
        .ptr   (rd_ptr),
        .addr  (rd_addr)
    );

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_valid_q <= pop_ok;
            if (bus.push && full_w)  overflow_q  <= 1'b1;
            if (bus.pop  && empty_w) underflow_q <= 1'b1;
        end
    end

    assign ram_en_w       = push_ok;
    assign ram_write_addr = wr_addr;
    assign ram_data       = bus.push_data;
    assign ram_en_r       = pop_ok;
    assign ram_read_addr  = rd_addr;

    assign bus.rd_data     = ram_out;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.almost_full = (count_q >= CNT_AFULL);
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

    // Count-derived flags must agree with the pointer relationship.
    a_full_ptr: assert property (@(posedge clk) disable iff (!reset)
        full_w == ((wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) && (wr_addr == rd_addr)));
    a_empty_ptr: assert property (@(posedge clk) disable iff (!reset)
        empty_w == (wr_ptr == rd_ptr));
endmodule

// File: tb/tb_fifo_ctrl_single_clock.sv
// Directed bench for fifo_ctrl_single_clock with a behavioural RAM alongside.
module tb_fifo_ctrl_single_clock;

    logic       clk;
    logic       reset;
    logic       ram_en_w;
    logic [3:0] ram_write_addr;
    logic [7:0] ram_data;
    logic       ram_en_r;
    logic [3:0] ram_read_addr;
    logic [7:0] ram_out;
    logic [7:0] mem [16];

    int n_cmp  = 0;
    int n_fail = 0;

    fifo_ctrl_single_clock_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    fifo_ctrl_single_clock #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_LEVEL(12)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .ram_en_w       (ram_en_w),
        .ram_write_addr (ram_write_addr),
        .ram_data       (ram_data),
        .ram_en_r       (ram_en_r),
        .ram_read_addr  (ram_read_addr),
        .ram_out        (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en_w) mem[ram_write_addr] <= ram_data;
        if (ram_en_r) ram_out <= mem[ram_read_addr];
    end

    typedef struct packed {
        logic       rst;
        logic       push;
        logic [7:0] din;
        logic       pop;
        logic       e_wen;
        logic       e_ren;
        logic [4:0] e_cnt;
        logic       e_empty;
        logic       e_full;
        logic       e_af;
        logic       e_rdv;
        logic [7:0] e_rd;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(logic rst, logic push, logic [7:0] din, logic pop,
                                logic wen, logic ren, logic [4:0] cnt, logic rdv,
                                logic [7:0] rd, logic ovf, logic unf);
        vec_t v;
        v.rst = rst;  v.push = push;  v.din = din;  v.pop = pop;
        v.e_wen = wen;  v.e_ren = ren;  v.e_cnt = cnt;
        v.e_empty = (cnt == 0);  v.e_full = (cnt == 16);  v.e_af = (cnt >= 12);
        v.e_rdv = rdv;  v.e_rd = rd;  v.e_ovf = ovf;  v.e_unf = unf;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp_v);
        end
    endtask

    task automatic drive(input logic rst, input logic push, input logic [7:0] din, input logic pop);
        reset         = ~rst;
        bus.push      = push;
        bus.push_data = din;
        bus.pop       = pop;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic rst, input logic push, input logic [7:0] din, input logic pop);
        drive(rst, push, din, pop);
        tick();
    endtask

    task automatic chk_status(input string nm, input int idx, input int cnt);
        chk({nm, "_count"}, idx, 32'(bus.count), 32'(cnt));
        chk({nm, "_empty"}, idx, 32'(bus.empty), 32'(cnt == 0));
        chk({nm, "_full"},  idx, 32'(bus.full),  32'(cnt == 16));
        chk({nm, "_afull"}, idx, 32'(bus.almost_full), 32'(cnt >= 12));
    endtask

    logic [7:0] sb [$];
    logic [7:0] exp_d;

    initial begin
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        tick();

        // reset, idle, 3-word push/pop, pop-on-empty, push+pop while empty, reset
        vecs[0]  = mk(1, 0, 8'h00, 0,  0, 0, 0,  0, 8'h00, 0, 0);
        vecs[1]  = mk(0, 0, 8'h00, 0,  0, 0, 0,  0, 8'h00, 0, 0);
        vecs[2]  = mk(0, 0, 8'h00, 0,  0, 0, 0,  0, 8'h00, 0, 0);
        vecs[3]  = mk(0, 0, 8'h00, 0,  0, 0, 0,  0, 8'h00, 0, 0);
        vecs[4]  = mk(0, 1, 8'h11, 0,  1, 0, 1,  0, 8'h00, 0, 0);
        vecs[5]  = mk(0, 1, 8'h22, 0,  1, 0, 2,  0, 8'h00, 0, 0);
        vecs[6]  = mk(0, 1, 8'h33, 0,  1, 0, 3,  0, 8'h00, 0, 0);
        vecs[7]  = mk(0, 0, 8'h00, 1,  0, 1, 2,  1, 8'h11, 0, 0);
        vecs[8]  = mk(0, 0, 8'h00, 1,  0, 1, 1,  1, 8'h22, 0, 0);
        vecs[9]  = mk(0, 0, 8'h00, 1,  0, 1, 0,  1, 8'h33, 0, 0);
        vecs[10] = mk(0, 0, 8'h00, 0,  0, 0, 0,  0, 8'h00, 0, 0);
        vecs[11] = mk(0, 0, 8'h00, 1,  0, 0, 0,  0, 8'h00, 0, 1);
        vecs[12] = mk(0, 0, 8'h00, 0,  0, 0, 0,  0, 8'h00, 0, 1);
        vecs[13] = mk(0, 1, 8'h44, 1,  1, 0, 1,  0, 8'h00, 0, 1);
        vecs[14] = mk(1, 0, 8'h00, 0,  0, 0, 0,  0, 8'h00, 0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].push, vecs[i].din, vecs[i].pop);
            #1;
            if (!vecs[i].rst) begin
                chk("v_wen", i, 32'(ram_en_w), 32'(vecs[i].e_wen));
                chk("v_ren", i, 32'(ram_en_r), 32'(vecs[i].e_ren));
            end
            tick();
            chk("v_count", i, 32'(bus.count), 32'(vecs[i].e_cnt));
            chk("v_empty", i, 32'(bus.empty), 32'(vecs[i].e_empty));
            chk("v_full",  i, 32'(bus.full),  32'(vecs[i].e_full));
            chk("v_afull", i, 32'(bus.almost_full), 32'(vecs[i].e_af));
            chk("v_rdv",   i, 32'(bus.rd_valid), 32'(vecs[i].e_rdv));
            if (vecs[i].e_rdv) chk("v_rdata", i, 32'(bus.rd_data), 32'(vecs[i].e_rd));
            chk("v_ovf",   i, 32'(bus.overflow),  32'(vecs[i].e_ovf));
            chk("v_unf",   i, 32'(bus.underflow), 32'(vecs[i].e_unf));
        end

        // fill to full, rejected push, drain in order
        cyc(1, 0, 8'h00, 0);
        for (int k = 0; k < 16; k++) begin
            drive(0, 1, 8'(k), 0);
            #1;
            chk("fill_wen", k, 32'(ram_en_w), 32'd1);
            tick();
            chk_status("fill", k, k + 1);
        end
        drive(0, 1, 8'hAA, 0);
        #1;
        chk("ovf_wen", 0, 32'(ram_en_w), 32'd0);
        tick();
        chk_status("ovf", 0, 16);
        chk("ovf_flag", 0, 32'(bus.overflow), 32'd1);
        for (int k = 0; k < 16; k++) begin
            cyc(0, 0, 8'h00, 1);
            chk("drain_rdv", k, 32'(bus.rd_valid), 32'd1);
            chk("drain_data", k, 32'(bus.rd_data), 32'(k));
            chk_status("drain", k, 15 - k);
        end
        cyc(0, 0, 8'h00, 0);
        chk("drain_end_rdv", 0, 32'(bus.rd_valid), 32'd0);
        chk("drain_end_ovf", 0, 32'(bus.overflow), 32'd1);

        // prefill 8 then stream push+pop every cycle across pointer wrap
        cyc(1, 0, 8'h00, 0);
        sb.delete();
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 8'h80 + 8'(k), 0);
            sb.push_back(8'h80 + 8'(k));
        end
        chk_status("prefill", 0, 8);
        for (int k = 0; k < 40; k++) begin
            exp_d = sb.pop_front();
            sb.push_back(8'(k * 7 + 3));
            cyc(0, 1, 8'(k * 7 + 3), 1);
            chk("strm_rdv", k, 32'(bus.rd_valid), 32'd1);
            chk("strm_data", k, 32'(bus.rd_data), 32'(exp_d));
            chk("strm_count", k, 32'(bus.count), 32'd8);
        end
        for (int k = 0; k < 8; k++) begin
            exp_d = sb.pop_front();
            cyc(0, 0, 8'h00, 1);
            chk("strm_drain", k, 32'(bus.rd_data), 32'(exp_d));
            chk("strm_drain_cnt", k, 32'(bus.count), 32'(7 - k));
        end
        chk("strm_ovf", 0, 32'(bus.overflow), 32'd0);
        chk("strm_unf", 0, 32'(bus.underflow), 32'd0);

        // reset mid-operation during a pop, then reuse
        cyc(1, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 1);
        chk("rst_unf_set", 0, 32'(bus.underflow), 32'd1);
        for (int k = 0; k < 5; k++) cyc(0, 1, 8'h60 + 8'(k), 0);
        chk_status("rst_pre", 0, 5);
        cyc(1, 0, 8'h00, 1);
        chk_status("rst_mid", 0, 0);
        chk("rst_mid_rdv", 0, 32'(bus.rd_valid), 32'd0);
        chk("rst_mid_unf", 0, 32'(bus.underflow), 32'd0);
        chk("rst_mid_ovf", 0, 32'(bus.overflow), 32'd0);
        cyc(0, 0, 8'h00, 0);
        chk("rst_after_rdv", 0, 32'(bus.rd_valid), 32'd0);
        cyc(0, 1, 8'h5A, 0);
        chk_status("rst_push", 0, 1);
        cyc(0, 0, 8'h00, 1);
        chk("rst_pop_rdv", 0, 32'(bus.rd_valid), 32'd1);
        chk("rst_pop_data", 0, 32'(bus.rd_data), 32'h5A);
        chk_status("rst_pop", 0, 0);
        cyc(0, 0, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_single_clock.md
Name: fifo_ctrl_single_clock

Overview:
- Single-clock FIFO controller wrapped around simple_dual_port_ram_dual_clock, with both RAM clocks tied to clk.
- Owns the write and read pointers, occupancy count, full/empty/almost-full flags and sticky error flags.
- Drives the RAM's write port and read-address port, and consumes ram_out, so it sits both upstream and downstream of the RAM.
- Presents a push/pop interface to producer and consumer logic, with 1-cycle read latency.

Parameters:
- DATA_WIDTH, 8, word width; must match the RAM instance.
- ADDR_WIDTH, 4, pointer address bits; FIFO depth DEPTH = 2**ADDR_WIDTH (16).
- AFULL_LEVEL, 12, occupancy at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
- clk  in  1  single clock; also drives RAM clk_w and clk_r.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk; also drives the RAM reset.
- push  in  1  producer write request.
- push_data  in  DATA_WIDTH  producer write word.
- pop  in  1  consumer read request.
- rd_data  out  DATA_WIDTH  read word; valid when rd_valid=1.
- rd_valid  out  1  rd_data holds the word of the pop accepted in the previous cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, range 0..DEPTH.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.
- ram_en_w  out  1  to RAM en_w.
- ram_write_addr  out  ADDR_WIDTH  to RAM write_addr.
- ram_data  out  DATA_WIDTH  to RAM data.
- ram_en_r  out  1  to RAM en_r.
- ram_read_addr  out  ADDR_WIDTH  to RAM read_addr.
- ram_out  in  DATA_WIDTH  from RAM ram_out.

Behaviour:
- Reset (reset==0 at a clk edge):
  - wr_ptr, rd_ptr, count = 0; rd_valid = 0; overflow = underflow = 0.
  - Result: empty=1, full=0, almost_full=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored words. Any pop accepted in the reset cycle produces no rd_valid.
- Pointers:
  - ADDR_WIDTH+1 bits, MSB is the wrap bit; the low ADDR_WIDTH bits address the RAM.
  - Each pointer increments by 1 per accepted op and wraps modulo 2*DEPTH.
- Accept rules (combinational):
  - push_ok = push & ~full.
  - pop_ok = pop & ~empty.
  - Evaluated against current-cycle flags only. Push while full is rejected even if pop_ok is 1 in the same cycle. Pop while empty is rejected even if push_ok is 1.
- Write path (combinational):
  - ram_en_w = push_ok; ram_write_addr = wr_ptr[ADDR_WIDTH-1:0]; ram_data = push_data.
  - The RAM writes on the same edge at which wr_ptr increments.
- Read path:
  - ram_en_r = pop_ok; ram_read_addr = rd_ptr[ADDR_WIDTH-1:0] (combinational).
  - The RAM registers ram_out on the accepting edge, and rd_valid <= pop_ok on that same edge.
  - rd_data = ram_out, combinational pass-through; latency is 1 cycle.
  - rd_data is don't-care when rd_valid=0.
- Count update:
  - Next count = count + push_ok − pop_ok.
  - Simultaneous push_ok and pop_ok leaves count unchanged; both pointers advance.
- Flags:
  - full, empty and almost_full are decoded from the registered count, so they are valid in the cycle after the op.
  - Cross-check assertion: full ⇔ (pointer MSBs differ & low bits equal); empty ⇔ (pointers equal).
- Error flags: overflow sets on push & full; underflow sets on pop & empty. Both clear only on reset.
- Write-then-read: a word pushed at edge T may be popped at edge T+1 with correct data, since the RAM write completes at edge T.
- Wrap-around: after DEPTH pushes and DEPTH pops, pointers = DEPTH (MSB=1, low bits=0) and FIFO order is preserved.

Decomposition:
- DataTypes package (existing DATA_WIDTH, ADDR_WIDTH, bit_t, DATA_W, ADDR_W), plus:
  - PTR_W: logic [ADDR_WIDTH:0].
  - CNT_W: logic [ADDR_WIDTH:0].
  - DEPTH constant.
- Sub-module fifo_ptr: a registered pointer with synchronous active-low reset and an increment enable. It outputs the full pointer and the address slice, and is instantiated twice (write and read).
- The RAM is instantiated at the top level next to this controller, not inside it.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, rd_valid=0, overflow=0, underflow=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 times -> rd_valid on the 3 following cycles with rd_data 0x11, 0x22, 0x33; count 3 -> 0; empty=1 at the end.
- Push 16 words 0x00..0x0F -> almost_full from count=12, full=1 at count=16. Push 0xAA -> rejected, overflow=1, count stays 16. Pop 16 -> data 0x00..0x0F in order; the 0xAA write never reaches the RAM.
- Pop while empty -> ram_en_r=0, rd_valid=0 next cycle, underflow=1 and held until reset.
- Prefill 8 words, then push and pop every cycle for 40 cycles -> count stays 8, pointers wrap past 32, and output order matches the input sequence.
- Fill to 5 words, assert reset for 1 cycle during a pop -> next cycle count=0, empty=1, rd_valid=0, flags cleared. A subsequent push 0x5A then pop returns 0x5A.
